// File: rtl/pwr_cmd_pkg.sv
// Shared types, status bit positions and the one-bit ramp step helper for
// the power-group command responder.
package pwr_cmd_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_SET_MASK = 3'd1,
    OP_OFF_ALL  = 3'd2,
    OP_SET_RAMP = 3'd3
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_RAMP,
    S_ACK
  } state_e;

  localparam int ACK_BIT  = 31;
  localparam int BUSY_BIT = 30;
  localparam int ERR_BIT  = 29;
  localparam int TGT_LSB  = 8;

  // Move cur one bit toward tgt: turning groups on takes priority (lowest
  // missing bit first), otherwise shed the highest surplus bit.
  function automatic logic [7:0] ramp_step(input logic [7:0] tgt, input logic [7:0] cur);
    logic [7:0] add, del, hb;
    add = tgt & ~cur;
    del = cur & ~tgt;
    hb  = '0;
    for (int i = 0; i < 8; i++)
      if (del[i]) hb = 8'd1 << i;
    if (add != '0) return cur | (add & (~add + 8'd1));
    return cur & ~hb;
  endfunction

endpackage

// File: rtl/gpio_cmd_sync.sv
// Two-flop bus synchroniser for the GPIO command word; the MSB (toggle
// strobe) gets a third flop so a change on it can be seen as a one-cycle edge.
module gpio_cmd_sync #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_s,
  output logic         tgl_edge
);

  logic [W-1:0] s1, s2;
  logic         s3;

  // Synchroniser chain; cleared in reset so a high strobe at release looks new.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= 1'b0;
    end else begin
      s1 <= data_in;
      s2 <= s1;
      s3 <= s2[W-1];
    end
  end

  assign data_s   = s2;
  assign tgl_edge = s2[W-1] ^ s3;

endmodule

// File: rtl/pwr_grp_cmd_responder.sv
// Decodes toggle-strobed GPIO commands, ramps per-group consumer enables one
// bit at a time and reports ack/busy/error status back on the GPIO input word.
// N_GROUPS must be 1..8 and RAMP_W at most 16 (ramp comes from the payload).
module pwr_grp_cmd_responder
  import pwr_cmd_pkg::*;
#(
  parameter int N_GROUPS     = 8,
  parameter int RAMP_W       = 16,
  parameter int RAMP_DEFAULT = 1000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [31:0]         gpio_cmd,
  output logic [31:0]         gpio_status,
  output logic [N_GROUPS-1:0] grp_en,
  output logic [1:0]          status_led
);

  logic [31:0]         cmd_s;
  logic                cmd_edge;
  state_e              state;
  logic [2:0]          op;
  logic [15:0]         payload;
  logic                tog, ack, error;
  logic [N_GROUPS-1:0] target, grp_nxt;
  logic [RAMP_W-1:0]   ramp_int, cnt, reload;
  logic [7:0]          cur8, tgt8, step8;
  logic [2:0]          new_op;
  logic                busy;
  logic [31:0]         status_nxt;
  logic                cmd_unused;

  gpio_cmd_sync #(.W(32)) u_sync (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .data_in  (gpio_cmd),
    .data_s   (cmd_s),
    .tgl_edge (cmd_edge)
  );

  assign cmd_unused = ^cmd_s[27:16];

  // Next ramp step, reload value (zero interval behaves as one) and status word.
  always_comb begin
    cur8 = '0;
    cur8[N_GROUPS-1:0] = grp_en;
    tgt8 = '0;
    tgt8[N_GROUPS-1:0] = target;
    step8   = ramp_step(tgt8, cur8);
    grp_nxt = step8[N_GROUPS-1:0];
    reload  = (ramp_int == '0) ? '0 : ramp_int - RAMP_W'(1);
    new_op  = cmd_s[30:28];
    busy    = (state != S_IDLE);
    status_nxt = '0;
    status_nxt[ACK_BIT]  = ack;
    status_nxt[BUSY_BIT] = busy;
    status_nxt[ERR_BIT]  = error;
    status_nxt[TGT_LSB +: N_GROUPS] = target;
    status_nxt[N_GROUPS-1:0]        = grp_en;
  end

  // Command FSM: decode, ramp and acknowledge; an OFF_ALL arriving while busy
  // aborts everything, any other early command only flags an error.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op       <= '0;
      payload  <= '0;
      tog      <= 1'b0;
      ack      <= 1'b0;
      error    <= 1'b0;
      target   <= '0;
      grp_en   <= '0;
      cnt      <= '0;
      ramp_int <= RAMP_W'(RAMP_DEFAULT);
    end else if (busy && cmd_edge && new_op == OP_OFF_ALL) begin
      grp_en <= '0;
      target <= '0;
      tog    <= cmd_s[31];
      ack    <= cmd_s[31];
      state  <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cmd_edge) begin
          op      <= new_op;
          payload <= cmd_s[15:0];
          tog     <= cmd_s[31];
          state   <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_ACK;
          error <= 1'b0;
          case (op)
            OP_NOP:      ;
            OP_SET_RAMP: ramp_int <= payload[RAMP_W-1:0];
            OP_OFF_ALL: begin
              grp_en <= '0;
              target <= '0;
            end
            OP_SET_MASK: begin
              target <= payload[N_GROUPS-1:0];
              cnt    <= '0;
              if (payload[N_GROUPS-1:0] != grp_en) state <= S_RAMP;
            end
            default:     error <= 1'b1;
          endcase
        end
        S_RAMP: begin
          if (cnt == '0) begin
            grp_en <= grp_nxt;
            cnt    <= reload;
            if (grp_nxt == target) state <= S_ACK;
          end else begin
            cnt <= cnt - RAMP_W'(1);
          end
        end
        S_ACK: begin
          ack   <= tog;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Protocol violation: command dropped, current work continues.
      if (busy && cmd_edge) error <= 1'b1;
    end
  end

  // Registered status outputs, one cycle behind the internal state.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      gpio_status <= '0;
      status_led  <= '0;
    end else begin
      gpio_status <= status_nxt;
      status_led  <= {error, busy};
    end
  end

endmodule

// File: tb/tb_pwr_grp_cmd_responder.sv
// Directed bench for the power-group command responder: a vector table of
// back-to-back commands plus hand-written multi-cycle corner sequences.
module tb_pwr_grp_cmd_responder;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [31:0] gpio_cmd;
  logic [31:0] gpio_status;
  logic [7:0]  grp_en;
  logic [1:0]  status_led;
  logic        tog;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk_in = ~clk_in;

  pwr_grp_cmd_responder #(.N_GROUPS(8), .RAMP_W(16), .RAMP_DEFAULT(1000)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .gpio_cmd    (gpio_cmd),
    .gpio_status (gpio_status),
    .grp_en      (grp_en),
    .status_led  (status_led)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] pl;
    int          lat;
    logic [7:0]  grp;
    logic [7:0]  tgt;
    logic        err;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] pl);
    @(negedge clk_in);
    tog = ~tog;
    gpio_cmd = {tog, op, 12'h000, pl};
  endtask

  // Count clock edges until ack==want with busy low; timeout counts as failure.
  task automatic wait_ack(input logic want, output int n);
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 3000) begin
      @(posedge clk_in);
      n++;
      @(negedge clk_in);
      if (gpio_status[31] == want && gpio_status[30] == 1'b0) done = 1;
    end
    if (!done) chk("ack_timeout", 32'(n), 32'hFFFF_FFFF);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    gpio_cmd = '0;
    tog = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] st(input logic a, input logic b, input logic e,
                                     input logic [7:0] t, input logic [7:0] g);
    return {a, b, e, 13'h0, t, g};
  endfunction

  initial begin
    int n;
    vt[0]  = '{3'd3, 16'h0004,  6, 8'h00, 8'h00, 1'b0};
    vt[1]  = '{3'd1, 16'h000F, 19, 8'h0F, 8'h0F, 1'b0};
    vt[2]  = '{3'd1, 16'h0003, 11, 8'h03, 8'h03, 1'b0};
    vt[3]  = '{3'd1, 16'h0003,  6, 8'h03, 8'h03, 1'b0};
    vt[4]  = '{3'd3, 16'h0001,  6, 8'h03, 8'h03, 1'b0};
    vt[5]  = '{3'd1, 16'h00FF, 12, 8'hFF, 8'hFF, 1'b0};
    vt[6]  = '{3'd2, 16'h0000,  6, 8'h00, 8'h00, 1'b0};
    vt[7]  = '{3'd5, 16'h0000,  6, 8'h00, 8'h00, 1'b1};
    vt[8]  = '{3'd0, 16'h0000,  6, 8'h00, 8'h00, 1'b0};
    vt[9]  = '{3'd3, 16'h0000,  6, 8'h00, 8'h00, 1'b0};
    vt[10] = '{3'd1, 16'h0081,  8, 8'h81, 8'h81, 1'b0};
    vt[11] = '{3'd1, 16'h007E, 14, 8'h7E, 8'h7E, 1'b0};
    vt[12] = '{3'd2, 16'h0000,  6, 8'h00, 8'h00, 1'b0};
    vt[13] = '{3'd1, 16'h00FF, 14, 8'hFF, 8'hFF, 1'b0};
    vt[14] = '{3'd1, 16'h01F0, 10, 8'hF0, 8'hF0, 1'b0};
    vt[15] = '{3'd7, 16'h0000,  6, 8'hF0, 8'hF0, 1'b1};
    vt[16] = '{3'd1, 16'h00F0,  6, 8'hF0, 8'hF0, 1'b0};

    rst_n = 1'b0;
    gpio_cmd = '0;
    tog = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_status", gpio_status, 32'h0);
    chk("rst_grp", {24'h0, grp_en}, 32'h0);
    chk("rst_led", {30'h0, status_led}, 32'h0);
    rst_n = 1'b1;

    // Back-to-back command table.
    for (int i = 0; i < 17; i++) begin
      issue(vt[i].op, vt[i].pl);
      wait_ack(tog, n);
      chk($sformatf("v%0d_lat", i), 32'(n), 32'(vt[i].lat));
      chk($sformatf("v%0d_grp", i), {24'h0, grp_en}, {24'h0, vt[i].grp});
      chk($sformatf("v%0d_status", i), gpio_status, st(tog, 1'b0, vt[i].err, vt[i].tgt, vt[i].grp));
      chk($sformatf("v%0d_led", i), {30'h0, status_led}, {30'h0, vt[i].err, 1'b0});
    end

    // Ramp step spacing: 0x01,0x03,0x07,0x0F four cycles apart.
    do_reset();
    issue(3'd3, 16'd4);
    wait_ack(tog, n);
    issue(3'd1, 16'h000F);
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      case (c)
        4:  chk("ramp_c4",  {24'h0, grp_en}, 32'h00);
        5:  chk("ramp_c5",  {24'h0, grp_en}, 32'h01);
        8:  chk("ramp_c8",  {24'h0, grp_en}, 32'h01);
        9:  chk("ramp_c9",  {24'h0, grp_en}, 32'h03);
        13: chk("ramp_c13", {24'h0, grp_en}, 32'h07);
        16: chk("ramp_c16", {24'h0, grp_en}, 32'h07);
        17: chk("ramp_c17", {24'h0, grp_en}, 32'h0F);
        18: chk("ramp_ack_early", {31'h0, gpio_status[31]}, {31'h0, ~tog});
        19: chk("ramp_done", gpio_status, st(tog, 1'b0, 1'b0, 8'h0F, 8'h0F));
        default: ;
      endcase
    end

    // Early SET_MASK mid-ramp: error, original ramp completes with original ack.
    issue(3'd1, 16'h00FF);
    repeat (8) @(negedge clk_in);
    issue(3'd1, 16'h0000);
    wait_ack(~tog, n);
    chk("viol_grp", {24'h0, grp_en}, 32'hFF);
    chk("viol_status", gpio_status, st(~tog, 1'b0, 1'b1, 8'hFF, 8'hFF));
    chk("viol_led", {30'h0, status_led}, 32'h2);

    // Early OFF_ALL mid-ramp: immediate abort, ack takes the new toggle.
    do_reset();
    issue(3'd3, 16'd4);
    wait_ack(tog, n);
    issue(3'd1, 16'h00FF);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
    end
    chk("abort_pre_grp", {24'h0, grp_en}, 32'h03);
    issue(3'd2, 16'h0000);
    repeat (3) @(negedge clk_in);
    chk("abort_grp", {24'h0, grp_en}, 32'h00);
    chk("abort_busy_c3", {31'h0, gpio_status[30]}, 32'h1);
    @(negedge clk_in);
    chk("abort_status", gpio_status, st(tog, 1'b0, 1'b0, 8'h00, 8'h00));
    repeat (6) @(negedge clk_in);
    chk("abort_quiet", {gpio_status[31:8], grp_en}, {tog, 31'h0});

    // Zero ramp interval: one bit per cycle; then reset mid-ramp.
    do_reset();
    issue(3'd3, 16'd0);
    wait_ack(tog, n);
    issue(3'd1, 16'h00FF);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (c == 5) chk("r0_c5", {24'h0, grp_en}, 32'h01);
      if (c == 8) chk("r0_c8", {24'h0, grp_en}, 32'h0F);
    end
    rst_n = 1'b0;
    tog = 1'b1;
    gpio_cmd = {1'b1, 31'h0};
    @(negedge clk_in);
    chk("midrst_grp", {24'h0, grp_en}, 32'h0);
    chk("midrst_status", gpio_status, 32'h0);
    chk("midrst_led", {30'h0, status_led}, 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;
    wait_ack(1'b1, n);
    chk("rel_strobe_lat", 32'(n), 32'd6);
    chk("rel_strobe_status", gpio_status, st(1'b1, 1'b0, 1'b0, 8'h00, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
